uart_echo_buffer: RTL and testbench

Parametrised successor to the UART loopback logic: an elastic echo buffer between the `uart_rx` byte stream and the `uart_tx` transmitter. It stores received bytes in a configurable-depth FIFO and drains them to the transmitter through an explicit busy-tracking handshake FSM. It exposes level, full, empty and sticky-overflow status, supports a synchronous flush, and drives the active-low receive-indicator LEDs. It sits in the top level between the `uart_rx` and `uart_tx` instances.

---
 rtl/uart_echo_buffer_pkg.sv | 19 +
 rtl/uart_echo_buffer_if.sv | 29 ++
 rtl/uart_echo_buffer_byte_fifo.sv | 74 +++++++
 rtl/uart_echo_buffer.sv | 148 ++++++++++++++
 tb/tb_uart_echo_buffer.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_echo_buffer_pkg.sv
// uart_echo_buffer shared types: drain FSM states and the
// control characters used by the optional CR/LF expansion.
package uart_echo_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  function automatic int tmr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_echo_buffer_if.sv
// Byte stream bundle between uart_rx, the echo buffer and
// uart_tx; master is the surrounding top level, slave the buffer.
interface uart_echo_buffer_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_busy;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;

  modport master (
    output rx_data,
    output rx_valid,
    output tx_busy,
    input  tx_data,
    input  tx_valid
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  tx_busy,
    output tx_data,
    output tx_valid
  );

endinterface

// File: rtl/uart_echo_buffer_byte_fifo.sv
// Power-of-two FIFO with registered level/full/empty flags;
// flush outranks both push and pop.
module byte_fifo
  import uart_echo_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rd_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL =
    (DEPTH_LOG2+1)'(DEPTH);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level_nxt;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    unique case (1'b1)
      flush:              level_nxt = '0;
      do_push && !do_pop: level_nxt = level + 1'b1;
      do_pop && !do_push: level_nxt = level - 1'b1;
      default:            level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push)
          wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)
          rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level_nxt;
      full  <= (level_nxt == FULL_LVL);
      empty <= (level_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_echo_buffer.sv
// Elastic echo buffer between uart_rx and uart_tx with busy-tracking
// drain FSM. Define UART_ECHO_CRLF_EN to follow each echoed CR with LF.
module uart_echo_buffer
  import uart_echo_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEPTH_LOG2   = 8,
  parameter int LED_W        = 6,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  uart_echo_buffer_if.slave   bus,
  input  logic                flush,
  output logic [LED_W-1:0]    led,
  output logic [DEPTH_LOG2:0] level,
  output logic                full,
  output logic                empty,
  output logic                overflow
);

  localparam logic [1:0] ST_IDLE      = IDLE;
  localparam logic [1:0] ST_SEND      = SEND;
  localparam logic [1:0] ST_WAIT_BUSY = WAIT_BUSY;
  localparam logic [1:0] ST_WAIT_DONE = WAIT_DONE;

  localparam int TW = tmr_w(BUSY_TIMEOUT);
  localparam logic [TW-1:0] TMR_LAST = TW'(BUSY_TIMEOUT - 1);

  logic [1:0]        state;
  logic [TW-1:0]     tmr;
  logic [DATA_W-1:0] head;
  logic              pop;
  logic              lf_req;
  logic              lf_go;
  logic              timed_out;

  byte_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (bus.rx_valid),
    .pop     (pop),
    .wr_data (bus.rx_data),
    .rd_data (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // A pending LF wins over queued data; flush suppresses new pops.
  assign lf_go = (state == ST_IDLE) && lf_req && !flush;
  assign pop   = (state == ST_IDLE) && !lf_req && !empty &&
                 !bus.tx_busy && !flush;

  assign timed_out = (state == ST_WAIT_BUSY) && !bus.tx_busy &&
                     (tmr == TMR_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      tmr          <= '0;
      bus.tx_data  <= '0;
      bus.tx_valid <= 1'b0;
    end else begin
      bus.tx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (lf_go) begin
            bus.tx_data  <= DATA_W'(CHAR_LF);
            bus.tx_valid <= 1'b1;
            state        <= ST_SEND;
          end else if (pop) begin
            bus.tx_data  <= head;
            bus.tx_valid <= 1'b1;
            state        <= ST_SEND;
          end
        end
        ST_SEND: begin
          tmr   <= '0;
          state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (bus.tx_busy)
            state <= ST_WAIT_DONE;
          else if (timed_out)
            state <= ST_IDLE;
          else
            tmr <= tmr + 1'b1;
        end
        ST_WAIT_DONE: begin
          if (!bus.tx_busy)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef UART_ECHO_CRLF_EN
  logic pend_lf;
  logic cur_cr;
  logic cr_done;

  // A CR that finishes, or times out, still earns its LF.
  assign cr_done = cur_cr &&
    (timed_out ||
     ((state == ST_WAIT_DONE) && !bus.tx_busy));

  assign lf_req = pend_lf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_lf <= 1'b0;
      cur_cr  <= 1'b0;
    end else begin
      if (lf_go)
        cur_cr <= 1'b0;
      else if (pop)
        cur_cr <= (head == DATA_W'(CHAR_CR));
      if (flush || lf_go)
        pend_lf <= 1'b0;
      else if (cr_done)
        pend_lf <= 1'b1;
    end
  end
`else
  assign lf_req = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led      <= '1;
      overflow <= 1'b0;
    end else begin
      if (bus.rx_valid)
        led <= ~bus.rx_data[LED_W-1:0];
      if (flush)
        overflow <= 1'b0;
      else if (bus.rx_valid && full)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Randomised and directed bench for uart_echo_buffer against a
// queue-based model of the echo behaviour.
module tb_uart_echo_buffer;

  localparam int DW    = 8;
  localparam int DL    = 2;
  localparam int LW    = 6;
  localparam int BT    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [LW-1:0] led;
  logic [DL:0]   level;
  logic          full;
  logic          empty;
  logic          overflow;

  uart_echo_buffer_if #(.DATA_W(DW)) bus ();

  uart_echo_buffer #(
    .DATA_W       (DW),
    .DEPTH_LOG2   (DL),
    .LED_W        (LW),
    .BUSY_TIMEOUT (BT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flush    (flush),
    .led      (led),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [7:0]    q[$];
  logic [LW-1:0] led_m;
  bit            ovf_m;
  bit            lf_m;
  bit            prev_txv;
  logic [7:0]    last_tx;
  bit            saw_full;
  bit            mon_en = 1'b0;
  int            cyc = 0;
  int            tx_cyc[$];
  logic [7:0]    tx_log[$];
  int            busy_len = 10;
  bit            never_busy = 1'b0;

  task automatic model_reset();
    q.delete();
    led_m    = '1;
    ovf_m    = 1'b0;
    lf_m     = 1'b0;
    prev_txv = 1'b0;
    last_tx  = 8'h00;
  endtask

  // Transmitter: busy rises the cycle after tx_valid, for busy_len cycles
  initial bus.tx_busy = 1'b0;
  always begin
    @(negedge clk);
    if (bus.tx_valid && !never_busy) begin
      @(posedge clk);
      #1 bus.tx_busy = 1'b1;
      repeat (busy_len) @(posedge clk);
      #1 bus.tx_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp_b;
    cyc++;
    if (mon_en && !rst) begin
      if (bus.tx_valid) begin
        check_eq("tx_pulse", prev_txv, 0);
        tx_cyc.push_back(cyc);
        tx_log.push_back(bus.tx_data);
        if (lf_m) begin
          check_eq("tx_lf", bus.tx_data, 8'h0A);
          lf_m = 1'b0;
        end else if (q.size() == 0) begin
          check_eq("tx_spurious", bus.tx_valid, 0);
        end else begin
          exp_b = q.pop_front();
          check_eq("tx_data", bus.tx_data, exp_b);
`ifdef UART_ECHO_CRLF_EN
          if (exp_b == 8'h0D)
            lf_m = 1'b1;
`endif
        end
        last_tx = bus.tx_data;
      end else begin
        check_eq("tx_hold", bus.tx_data, last_tx);
      end
      prev_txv = bus.tx_valid;
      check_eq("level", level, q.size());
      check_eq("full", full, q.size() == DEPTH);
      check_eq("empty", empty, q.size() == 0);
      check_eq("overflow", overflow, ovf_m);
      check_eq("led", led, led_m);
      if (full)
        saw_full = 1'b1;
      if (flush) begin
        q.delete();
        ovf_m = 1'b0;
        lf_m  = 1'b0;
      end else if (bus.rx_valid) begin
        if (q.size() < DEPTH)
          q.push_back(bus.rx_data);
        else
          ovf_m = 1'b1;
      end
      if (bus.rx_valid)
        led_m = ~bus.rx_data[LW-1:0];
    end
  end

  task automatic put(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
  endtask

  task automatic rx_off();
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_txv"}, bus.tx_valid, 0);
    check_eq({tag, "_txd"}, bus.tx_data, 0);
    check_eq({tag, "_led"}, led, 6'h3F);
    check_eq({tag, "_lvl"}, level, 0);
    check_eq({tag, "_empty"}, empty, 1);
    check_eq({tag, "_full"}, full, 0);
    check_eq({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    int n0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    model_reset();
    cycles(3);
    #1 check_reset_vals("rst");
    @(negedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Single byte latency
    busy_len = 10;
    cycles(2);
    put(8'h41);
    rx_off();
    @(negedge clk);
    check_eq("single_lvl1", level, 1);
    @(negedge clk);
    check_eq("single_txv", bus.tx_valid, 1);
    check_eq("single_txd", bus.tx_data, 8'h41);
    check_eq("single_lvl0", level, 0);
    check_eq("single_led", led, 6'b111110);
    cycles(30);

    // Burst into a 4-deep FIFO
    busy_len = 20;
    saw_full = 1'b0;
    n0 = tx_log.size();
    for (int i = 1; i <= 6; i++)
      put(8'(i));
    rx_off();
    cycles(200);
    @(negedge clk);
    check_eq("burst_cnt", tx_log.size() - n0, 5);
    for (int k = 0; k < 5; k++)
      check_eq("burst_byte", tx_log[n0+k], k + 1);
    for (int k = 0; k < 4; k++)
      check_eq("burst_gap", tx_cyc[n0+k+1] - tx_cyc[n0+k], 23);
    check_eq("burst_ovf", overflow, 1);
    check_eq("burst_full", saw_full, 1);

    // Flush during WAIT_DONE of the first byte
    busy_len = 10;
    n0 = tx_log.size();
    put(8'h11);
    put(8'h22);
    put(8'h33);
    rx_off();
    cycles(2);
    #1 flush = 1'b1;
    check_eq("flush_inflight", tx_log.size() - n0, 1);
    @(posedge clk);
    #1 flush = 1'b0;
    cycles(60);
    @(negedge clk);
    check_eq("flush_cnt", tx_log.size() - n0, 1);
    check_eq("flush_byte", tx_log[n0], 8'h11);
    check_eq("flush_lvl", level, 0);
    check_eq("flush_ovf", overflow, 0);
    check_eq("flush_empty", empty, 1);

    // Busy never asserted: timeout then next byte
    never_busy = 1'b1;
    n0 = tx_log.size();
    put(8'h5A);
    put(8'hA5);
    rx_off();
    cycles(60);
    @(negedge clk);
    check_eq("tmo_cnt", tx_log.size() - n0, 2);
    check_eq("tmo_b0", tx_log[n0], 8'h5A);
    check_eq("tmo_b1", tx_log[n0+1], 8'hA5);
    check_eq("tmo_gap", tx_cyc[n0+1] - tx_cyc[n0], BT + 2);
    never_busy = 1'b0;

    // CR handling at minimum spacing
    busy_len = 1;
    n0 = tx_log.size();
    put(8'h0D);
    put(8'h42);
    rx_off();
    cycles(40);
    @(negedge clk);
`ifdef UART_ECHO_CRLF_EN
    check_eq("crlf_cnt", tx_log.size() - n0, 3);
    check_eq("crlf_b0", tx_log[n0], 8'h0D);
    check_eq("crlf_b1", tx_log[n0+1], 8'h0A);
    check_eq("crlf_b2", tx_log[n0+2], 8'h42);
    check_eq("crlf_gap0", tx_cyc[n0+1] - tx_cyc[n0], 4);
    check_eq("crlf_gap1", tx_cyc[n0+2] - tx_cyc[n0+1], 4);
`else
    check_eq("cr_cnt", tx_log.size() - n0, 2);
    check_eq("cr_b0", tx_log[n0], 8'h0D);
    check_eq("cr_b1", tx_log[n0+1], 8'h42);
    check_eq("cr_gap", tx_cyc[n0+1] - tx_cyc[n0], 4);
`endif

    // Random traffic, model-checked every cycle
    for (int c = 0; c < 500; c++) begin
      if (c % 100 == 0)
        busy_len = $urandom_range(1, 6);
      @(posedge clk);
      #1;
      bus.rx_valid = ($urandom_range(0, 2) == 0);
      bus.rx_data  = ($urandom_range(0, 7) == 0) ?
                     8'h0D : 8'($urandom);
    end
    rx_off();
    cycles(400);
    @(negedge clk);
    check_eq("rand_drain", q.size(), 0);

    // Reset during WAIT_BUSY with a byte still queued
    never_busy = 1'b1;
    put(8'h55);
    put(8'h66);
    rx_off();
    cycles(3);
    @(negedge clk);
    mon_en = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_vals("arst");
    cycles(2);
    @(negedge clk);
    #1 rst = 1'b0;
    model_reset();
    never_busy = 1'b0;
    n0 = tx_log.size();
    mon_en = 1'b1;
    cycles(40);
    @(negedge clk);
    check_eq("arst_empty", empty, 1);
    check_eq("arst_lvl", level, 0);
    check_eq("arst_notx", tx_log.size() - n0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
